// File: rtl/dmem_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_bus_ctrl_if
//
// External data-memory bus between the memory-stage controller (master) and
// the memory/bus fabric (slave). The request fields are registered in the
// master and held stable until the slave answers with bus_ack_i.
//
// Signals
//   bus_req_o    master -> slave  request valid, held until acknowledged
//   bus_we_o     master -> slave  1 = write, 0 = read
//   bus_addr_o   master -> slave  byte address
//   bus_sel_o    master -> slave  byte-lane select, bit3 = data bits 31:24
//   bus_wdata_o  master -> slave  store data
//   bus_ack_i    slave  -> master transfer complete (one cycle)
//   bus_rdata_i  slave  -> master load data, valid with bus_ack_i
// -----------------------------------------------------------------------------
interface dmem_bus_ctrl_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o,
        output bus_we_o,
        output bus_addr_o,
        output bus_sel_o,
        output bus_wdata_o,
        input  bus_ack_i,
        input  bus_rdata_i
    );

    modport slave (
        input  bus_req_o,
        input  bus_we_o,
        input  bus_addr_o,
        input  bus_sel_o,
        input  bus_wdata_o,
        output bus_ack_i,
        output bus_rdata_i
    );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_bus_ctrl
//
// Memory-stage data-bus controller. Turns a single-cycle access request from
// the pipeline into a registered request/acknowledge transaction on the
// external bus, stalls the pipeline while the access is outstanding and
// returns the load data for exactly one DONE cycle.
//
// States
//   IDLE  : waiting for ce_i; a request is launched on the clock edge
//   BUSY  : request held on the bus until bus_ack_i
//   DONE  : one cycle with rdata_o valid and the stall released
//   DRAIN : access was flushed while outstanding; the bus handshake is
//           completed and its data thrown away before anything new launches
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   flush        pipeline flush/exception, cancels the current access
//   ce_i         memory-stage access enable
//   we_i         write enable (already exception-masked)
//   addr_i       access address
//   sel_i        byte-lane select
//   wdata_i      store data
//   rdata_o      load data (writes return 0), held between accesses
//   stall_req_o  combinational stall request to the pipeline controller
//   bus          dmem_bus_ctrl_if.master, registered external bus
//   bus_err_o    one-cycle timeout pulse (only with DMEM_TIMEOUT_EN)
//
// Configuration
//   TIMEOUT_CYCLES   maximum wait cycles in BUSY/DRAIN, 1..255
//   DMEM_TIMEOUT_EN  macro; when defined an 8-bit watchdog aborts a stalled
//                    bus access after TIMEOUT_CYCLES cycles without ack.
//                    When undefined the controller waits for ack forever
//                    and bus_err_o does not exist.
// -----------------------------------------------------------------------------
module dmem_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   ce_i,
    input  logic                   we_i,
    input  logic [31:0]            addr_i,
    input  logic [3:0]             sel_i,
    input  logic [31:0]            wdata_i,
    output logic [31:0]            rdata_o,
    output logic                   stall_req_o,
    dmem_bus_ctrl_if.master        bus
`ifdef DMEM_TIMEOUT_EN
    ,
    output logic                   bus_err_o
`endif
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("dmem_bus_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        launch;     // load the bus request registers from the pipeline
    logic        bus_clear;  // transaction finished: return the bus to all-zero
    logic        capture;    // update rdata_o with rdata_cap
    logic        tmo_hit;    // watchdog expires in this cycle
    logic [31:0] rdata_cap;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt;
    logic       tmo_restart;

    // The counter holds the number of ack-less cycles already spent in the
    // current state, so the last allowed cycle is the one where it reads
    // TIMEOUT_CYCLES-1 and still no ack arrives.
    assign tmo_hit     = (state == BUSY || state == DRAIN) && !bus.bus_ack_i
                         && (tmo_cnt == TMO_LAST);
    assign tmo_restart = launch || (state == BUSY && state_nxt == DRAIN);
`else
    assign tmo_hit = 1'b0;
`endif

    // Writes and aborted accesses return zero instead of whatever is on
    // bus_rdata_i.
    assign rdata_cap = (bus.bus_we_o || tmo_hit) ? 32'd0 : bus.bus_rdata_i;

    // ---- next-state and stall decode ---------------------------------------
    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        bus_clear   = 1'b0;
        capture     = 1'b0;
        stall_req_o = 1'b0;

        case (state)
            IDLE: begin
                stall_req_o = ce_i & ~flush;
                if (ce_i && !flush) begin
                    launch    = 1'b1;
                    state_nxt = BUSY;
                end
            end

            BUSY: begin
                stall_req_o = ~flush;
                if (bus.bus_ack_i) begin
                    bus_clear = 1'b1;
                    if (flush) begin
                        // Ack and flush together: the data belongs to a
                        // cancelled instruction, drop it.
                        state_nxt = IDLE;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (tmo_hit) begin
                    bus_clear = 1'b1;
                    if (flush) begin
                        state_nxt = IDLE;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (flush) begin
                    // The bus must see its handshake through; keep the
                    // request up and finish it in DRAIN.
                    state_nxt = DRAIN;
                end
            end

            DONE: begin
                // ce_i is still high for the instruction that just completed;
                // ignoring it here keeps the access from launching twice.
                state_nxt = IDLE;
            end

            DRAIN: begin
                // A new access may already be waiting; stall it until the
                // flushed transaction has been acknowledged.
                stall_req_o = ce_i & ~flush;
                if (bus.bus_ack_i || tmo_hit) begin
                    bus_clear = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (!rst) begin
            stall_req_o = 1'b0;
        end
    end

    // ---- state register -----------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- registered bus request ---------------------------------------------
    // Fields are only non-zero while bus_req_o is high; reset drops the
    // request immediately, even mid-handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.bus_req_o   <= 1'b0;
            bus.bus_we_o    <= 1'b0;
            bus.bus_addr_o  <= 32'd0;
            bus.bus_sel_o   <= 4'd0;
            bus.bus_wdata_o <= 32'd0;
        end else if (launch) begin
            bus.bus_req_o   <= 1'b1;
            bus.bus_we_o    <= we_i;
            bus.bus_addr_o  <= addr_i;
            bus.bus_sel_o   <= sel_i;
            bus.bus_wdata_o <= wdata_i;
        end else if (bus_clear) begin
            bus.bus_req_o   <= 1'b0;
            bus.bus_we_o    <= 1'b0;
            bus.bus_addr_o  <= 32'd0;
            bus.bus_sel_o   <= 4'd0;
            bus.bus_wdata_o <= 32'd0;
        end
    end

    // ---- load data return ---------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_o <= 32'd0;
        end else if (capture) begin
            rdata_o <= rdata_cap;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    // ---- watchdog -----------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt   <= 8'd0;
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= tmo_hit;
            if (tmo_restart) begin
                tmo_cnt <= 8'd0;
            end else if ((state == BUSY || state == DRAIN) && !bus.bus_ack_i) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_ctrl
//
// Directed bench for dmem_bus_ctrl. The driver applies one cycle of inputs at
// a time and queues the hand-computed expected outputs for that cycle; each
// expected bus request is queued when the access is issued. A monitor on the
// falling edge pops and compares: per-cycle outputs every cycle, and a bus
// request entry whenever bus_req_o rises.
// -----------------------------------------------------------------------------
module tb_dmem_bus_ctrl;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
`ifdef DMEM_TIMEOUT_EN
    logic        bus_err;
`endif

    dmem_bus_ctrl_if bus_if ();

    dmem_bus_ctrl #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .ce_i        (ce),
        .we_i        (we),
        .addr_i      (addr),
        .sel_i       (sel),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .stall_req_o (stall),
        .bus         (bus_if)
`ifdef DMEM_TIMEOUT_EN
        ,
        .bus_err_o   (bus_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        req;
        logic [1:0]  st;
        logic [31:0] rdata;
        logic        err;
    } cyc_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } req_t;

    cyc_t exp_cyc_q[$];
    req_t exp_req_q[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    logic started  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---- monitor ------------------------------------------------------------
    logic prev_req = 1'b0;
    req_t cur_req;

    always @(negedge clk) begin
        if (started) begin
            if (exp_cyc_q.size() > 0) begin
                cyc_t e;
                e = exp_cyc_q.pop_front();
                check("stall_req", 32'(stall), 32'(e.stall));
                check("bus_req", 32'(bus_if.bus_req_o), 32'(e.req));
                check("state", 32'(dut.state), 32'(e.st));
                check("rdata", rdata, e.rdata);
`ifdef DMEM_TIMEOUT_EN
                check("bus_err", 32'(bus_err), 32'(e.err));
`endif
            end

            if (bus_if.bus_req_o) begin
                if (!prev_req) begin
                    if (exp_req_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_request at %0t: got addr %h, expected no request",
                                 $time, bus_if.bus_addr_o);
                        cur_req = '{we: bus_if.bus_we_o, addr: bus_if.bus_addr_o,
                                    sel: bus_if.bus_sel_o, wdata: bus_if.bus_wdata_o};
                    end else begin
                        cur_req = exp_req_q.pop_front();
                    end
                end
                // Checked on every request cycle: launch values and stability.
                check("bus_we", 32'(bus_if.bus_we_o), 32'(cur_req.we));
                check("bus_addr", bus_if.bus_addr_o, cur_req.addr);
                check("bus_sel", 32'(bus_if.bus_sel_o), 32'(cur_req.sel));
                check("bus_wdata", bus_if.bus_wdata_o, cur_req.wdata);
            end else begin
                check("idle_bus_fields",
                      bus_if.bus_addr_o | bus_if.bus_wdata_o | 32'(bus_if.bus_sel_o)
                      | 32'(bus_if.bus_we_o), 32'd0);
            end
            prev_req <= bus_if.bus_req_o;
        end
    end

    // ---- driver helpers -----------------------------------------------------
    task automatic cyc(input logic s, input logic r, input logic [1:0] st,
                       input logic [31:0] rd, input logic e = 1'b0);
        cyc_t c;
        c = '{stall: s, req: r, st: st, rdata: rd, err: e};
        exp_cyc_q.push_back(c);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_req(input logic w, input logic [31:0] a,
                              input logic [3:0] s, input logic [31:0] d);
        req_t q;
        q = '{we: w, addr: a, sel: s, wdata: d};
        exp_req_q.push_back(q);
    endtask

    task automatic set_in(input logic c, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d);
        ce    = c;
        we    = w;
        addr  = a;
        sel   = s;
        wdata = d;
    endtask

    task automatic set_bus(input logic ack, input logic [31:0] rd);
        bus_if.bus_ack_i   = ack;
        bus_if.bus_rdata_i = rd;
    endtask

    logic [31:0] rd_now;

    // ---- stimulus -----------------------------------------------------------
    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        set_in(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        set_bus(1'b0, 32'd0);
        @(posedge clk);
        #1;
        started = 1'b1;

        // Reset: outputs zero, stall forced low even with ce high.
        cyc(1'b0, 1'b0, S_IDLE, 32'd0);
        set_in(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'd0);
        cyc(1'b0, 1'b0, S_IDLE, 32'd0);
        rst = 1'b1;
        set_in(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        cyc(1'b0, 1'b0, S_IDLE, 32'd0);

        // Zero-wait load.
        set_in(1'b1, 1'b0, 32'h8000_1004, 4'hF, 32'd0);
        expect_req(1'b0, 32'h8000_1004, 4'hF, 32'd0);
        cyc(1'b1, 1'b0, S_IDLE, 32'd0);
        set_in(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        set_bus(1'b1, 32'hDEAD_BEEF);
        cyc(1'b1, 1'b1, S_BUSY, 32'd0);
        set_bus(1'b0, 32'd0);
        cyc(1'b0, 1'b0, S_DONE, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b0, S_IDLE, 32'hDEAD_BEEF);

        // Flush in the 2nd BUSY cycle, ack 3 cycles later; a new access
        // requested during DRAIN waits for that ack.
        set_in(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'd0);
        expect_req(1'b0, 32'h0000_0100, 4'hF, 32'd0);
        cyc(1'b1, 1'b0, S_IDLE, 32'hDEAD_BEEF);
        set_in(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        cyc(1'b1, 1'b1, S_BUSY, 32'hDEAD_BEEF);
        flush = 1'b1;
        cyc(1'b0, 1'b1, S_BUSY, 32'hDEAD_BEEF);
        flush = 1'b0;
        cyc(1'b0, 1'b1, S_DRAIN, 32'hDEAD_BEEF);
        set_in(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'd0);
        cyc(1'b1, 1'b1, S_DRAIN, 32'hDEAD_BEEF);
        set_bus(1'b1, 32'hAAAA_5555);
        cyc(1'b1, 1'b1, S_DRAIN, 32'hDEAD_BEEF);
        set_bus(1'b0, 32'd0);
        expect_req(1'b0, 32'h0000_0200, 4'hF, 32'd0);
        cyc(1'b1, 1'b0, S_IDLE, 32'hDEAD_BEEF);
        set_in(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        set_bus(1'b1, 32'h0BAD_F00D);
        cyc(1'b1, 1'b1, S_BUSY, 32'hDEAD_BEEF);
        set_bus(1'b0, 32'd0);
        cyc(1'b0, 1'b0, S_DONE, 32'h0BAD_F00D);
        cyc(1'b0, 1'b0, S_IDLE, 32'h0BAD_F00D);

        // Flush and ack in the same BUSY cycle: data discarded.
        set_in(1'b1, 1'b0, 32'h0000_0300, 4'hF, 32'd0);
        expect_req(1'b0, 32'h0000_0300, 4'hF, 32'd0);
        cyc(1'b1, 1'b0, S_IDLE, 32'h0BAD_F00D);
        set_in(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        flush = 1'b1;
        set_bus(1'b1, 32'h1111_1111);
        cyc(1'b0, 1'b1, S_BUSY, 32'h0BAD_F00D);
        flush = 1'b0;
        set_bus(1'b0, 32'd0);
        cyc(1'b0, 1'b0, S_IDLE, 32'h0BAD_F00D);

        // Store with 4 BUSY cycles; write returns 0 regardless of bus_rdata.
        set_in(1'b1, 1'b1, 32'h0000_0040, 4'h3, 32'h1234_1234);
        expect_req(1'b1, 32'h0000_0040, 4'h3, 32'h1234_1234);
        cyc(1'b1, 1'b0, S_IDLE, 32'h0BAD_F00D);
        set_in(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, S_BUSY, 32'h0BAD_F00D);
        set_bus(1'b1, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b1, S_BUSY, 32'h0BAD_F00D);
        set_bus(1'b0, 32'd0);
        cyc(1'b0, 1'b0, S_DONE, 32'd0);
        cyc(1'b0, 1'b0, S_IDLE, 32'd0);

        // Back-to-back loads with ce held high across DONE.
        set_in(1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'd0);
        expect_req(1'b0, 32'h0000_1000, 4'hF, 32'd0);
        cyc(1'b1, 1'b0, S_IDLE, 32'd0);
        set_in(1'b1, 1'b0, 32'h0000_2000, 4'hF, 32'd0);
        set_bus(1'b1, 32'hCAFE_0001);
        cyc(1'b1, 1'b1, S_BUSY, 32'd0);
        set_bus(1'b0, 32'd0);
        cyc(1'b0, 1'b0, S_DONE, 32'hCAFE_0001);
        expect_req(1'b0, 32'h0000_2000, 4'hF, 32'd0);
        cyc(1'b1, 1'b0, S_IDLE, 32'hCAFE_0001);
        set_in(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        set_bus(1'b1, 32'hCAFE_0002);
        cyc(1'b1, 1'b1, S_BUSY, 32'hCAFE_0001);
        set_bus(1'b0, 32'd0);
        cyc(1'b0, 1'b0, S_DONE, 32'hCAFE_0002);
        cyc(1'b0, 1'b0, S_IDLE, 32'hCAFE_0002);

`ifdef DMEM_TIMEOUT_EN
        // No ack: request drops after 4 BUSY cycles, one error pulse, DONE
        // with zero data.
        set_in(1'b1, 1'b0, 32'h0000_0600, 4'hF, 32'd0);
        expect_req(1'b0, 32'h0000_0600, 4'hF, 32'd0);
        cyc(1'b1, 1'b0, S_IDLE, 32'hCAFE_0002);
        set_in(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, S_BUSY, 32'hCAFE_0002);
        cyc(1'b0, 1'b0, S_DONE, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, S_IDLE, 32'd0);
        rd_now = 32'd0;
`else
        // Long wait: no timeout, the request is held until the ack.
        set_in(1'b1, 1'b0, 32'h0000_0500, 4'hC, 32'd0);
        expect_req(1'b0, 32'h0000_0500, 4'hC, 32'd0);
        cyc(1'b1, 1'b0, S_IDLE, 32'hCAFE_0002);
        set_in(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, S_BUSY, 32'hCAFE_0002);
        set_bus(1'b1, 32'h5A5A_5A5A);
        cyc(1'b1, 1'b1, S_BUSY, 32'hCAFE_0002);
        set_bus(1'b0, 32'd0);
        cyc(1'b0, 1'b0, S_DONE, 32'h5A5A_5A5A);
        cyc(1'b0, 1'b0, S_IDLE, 32'h5A5A_5A5A);
        rd_now = 32'h5A5A_5A5A;
`endif

        // Reset while BUSY: request drops on the next edge, all outputs 0.
        set_in(1'b1, 1'b1, 32'h0000_0700, 4'hF, 32'h0000_0077);
        expect_req(1'b1, 32'h0000_0700, 4'hF, 32'h0000_0077);
        cyc(1'b1, 1'b0, S_IDLE, rd_now);
        set_in(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b1, S_BUSY, rd_now);
        rst = 1'b1;
        cyc(1'b0, 1'b0, S_IDLE, 32'd0);
        cyc(1'b0, 1'b0, S_IDLE, 32'd0);

        // Let the monitor consume everything, bounded.
        for (int i = 0; i < 10 && exp_cyc_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        check("cycle_queue_left", 32'(exp_cyc_q.size()), 32'd0);
        check("request_queue_left", 32'(exp_req_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
